// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers.
// An accepted op holds busy for MUL_CYCLES or DIV_CYCLES cycles; the result
// lands in HI/LO on the edge where busy falls. Divide by zero leaves HI/LO as-is.
module md_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [1:0]        op_q, op_next;
    logic [31:0]       a_q, a_next;
    logic [31:0]       b_q, b_next;
    logic [31:0]       hi_next, lo_next;
    logic              busy_next;

    logic [63:0]       prod_s, prod_u;
    logic              div_zero, a_neg, b_neg;
    logic [31:0]       a_mag, b_mag, q_mag, r_mag, quot, rem;

    // Result datapath on the latched operands; signed divide via magnitudes so
    // 0x80000000 / -1 wraps to 0x80000000 without an overflow corner.
    always_comb begin
        prod_s   = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u   = {32'd0, a_q} * {32'd0, b_q};
        div_zero = (b_q == 32'd0);
        a_neg    = !op_q[0] && a_q[31];
        b_neg    = !op_q[0] && b_q[31];
        a_mag    = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag    = div_zero ? 32'd1 : (b_neg ? (~b_q + 32'd1) : b_q);
        q_mag    = a_mag / b_mag;
        r_mag    = a_mag % b_mag;
        quot     = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem      = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // Next-state, operand latch, counter and HI/LO update logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        op_next    = op_q;
        a_next     = a_q;
        b_next     = b_q;
        hi_next    = hi;
        lo_next    = lo;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                    op_next    = op;
                    a_next     = rs_data;
                    b_next     = rt_data;
                    cnt_next   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                end else begin
                    if (mthi) hi_next = wdata;
                    if (mtlo) lo_next = wdata;
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    if (!op_q[1]) begin
                        hi_next = op_q[0] ? prod_u[63:32] : prod_s[63:32];
                        lo_next = op_q[0] ? prod_u[31:0]  : prod_s[31:0];
                    end else if (!div_zero) begin
                        hi_next = rem;
                        lo_next = quot;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next == BUSY);
    end

    // State, operand and architectural register update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= 2'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            op_q  <= op_next;
            a_q   <= a_next;
            b_q   <= b_next;
            hi    <= hi_next;
            lo    <= lo_next;
            busy  <= busy_next;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit; expected {HI,LO} pushed at issue,
// popped and compared when busy falls.
module tb_md_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int passed = 0;
    int total  = 0;

    logic [63:0] model_hilo = 64'd0;
    logic [63:0] exp_q[$];
    logic [63:0] exp;
    int          cyc;

    md_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
        .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        longint sa, sb, q, r;
        logic [63:0] qq, rr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'd0: return 64'(sa * sb);
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) return cur;
                q = sa / sb;
                r = sa % sb;
                qq = 64'(q);
                rr = 64'(r);
                return {rr[31:0], qq[31:0]};
            end
            default: begin
                if (b == 32'd0) return cur;
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Drive a start at the current negedge and push the expected result.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        model_hilo = model(o, a, b, model_hilo);
        exp_q.push_back(model_hilo);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
    endtask

    // Count busy cycles; kind 1 pulses mtlo, 2 pulses start, 3 pulses reset at busy cycle 'at'.
    task automatic wait_busy(input int kind, input int at, output int cycles);
        bit done;
        done   = 1'b0;
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            mthi  = 1'b0;
            mtlo  = 1'b0;
            reset = 1'b0;
            if (!busy) begin
                done = 1'b1;
                break;
            end
            cycles++;
            if (cycles == at) begin
                case (kind)
                    1: begin mtlo = 1'b1; wdata = 32'hDEADBEEF; end
                    2: begin start = 1'b1; op = 2'd0; rs_data = 32'd5; rt_data = 32'd5; end
                    3: reset = 1'b1;
                    default: ;
                endcase
            end
        end
        if (!done) cycles = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (hi !== 32'd0) $display("FAIL reset_hi got %h want 0", hi); else passed++;
        total++; if (lo !== 32'd0) $display("FAIL reset_lo got %h want 0", lo); else passed++;
        reset = 1'b0;
        model_hilo = 64'd0;
        @(negedge clk);
    endtask

    task automatic test_mult;
        issue(2'd0, 32'hFFFFFFFE, 32'h00000003);
        wait_busy(0, 0, cyc);
        total++; if (cyc !== MUL_N) $display("FAIL mult_busy_len got %0d want %0d", cyc, MUL_N); else passed++;
        exp = exp_q.pop_front();
        total++; if ({hi, lo} !== exp || exp !== 64'hFFFFFFFF_FFFFFFFA)
            $display("FAIL mult_result got %h_%h want %h", hi, lo, exp); else passed++;
    endtask

    task automatic test_multu;
        issue(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_busy(0, 0, cyc);
        total++; if (cyc !== MUL_N) $display("FAIL multu_busy_len got %0d want %0d", cyc, MUL_N); else passed++;
        exp = exp_q.pop_front();
        total++; if ({hi, lo} !== exp) $display("FAIL multu_result got %h_%h want %h", hi, lo, exp); else passed++;
    endtask

    task automatic test_div;
        issue(2'd2, 32'hFFFFFFF9, 32'd2);
        wait_busy(0, 0, cyc);
        total++; if (cyc !== DIV_N) $display("FAIL div_busy_len got %0d want %0d", cyc, DIV_N); else passed++;
        exp = exp_q.pop_front();
        total++; if ({hi, lo} !== exp) $display("FAIL div_result got %h_%h want %h", hi, lo, exp); else passed++;
        issue(2'd3, 32'hFFFFFFF9, 32'd2);
        wait_busy(0, 0, cyc);
        exp = exp_q.pop_front();
        total++; if ({hi, lo} !== exp) $display("FAIL divu_result got %h_%h want %h", hi, lo, exp); else passed++;
        issue(2'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_busy(0, 0, cyc);
        exp = exp_q.pop_front();
        total++; if ({hi, lo} !== exp) $display("FAIL div_overflow got %h_%h want %h", hi, lo, exp); else passed++;
    endtask

    task automatic test_moves;
        mthi  = 1'b1;
        wdata = 32'h12345678;
        #1;
        total++; if (hi !== model_hilo[63:32]) $display("FAIL mthi_no_bypass got %h want %h", hi, model_hilo[63:32]); else passed++;
        @(negedge clk);
        mthi = 1'b0;
        model_hilo[63:32] = 32'h12345678;
        total++; if (hi !== 32'h12345678) $display("FAIL mthi_write got %h want 12345678", hi); else passed++;
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'hA5A5C3C3;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        model_hilo = {32'hA5A5C3C3, 32'hA5A5C3C3};
        total++; if ({hi, lo} !== model_hilo) $display("FAIL mthi_mtlo_both got %h_%h want %h", hi, lo, model_hilo); else passed++;
        // start with mthi in the same cycle: divide by zero keeps HI, so a leaked move would show
        issue(2'd2, 32'd77, 32'd0);
        mthi  = 1'b1;
        wdata = 32'h0BADF00D;
        wait_busy(0, 0, cyc);
        exp = exp_q.pop_front();
        total++; if ({hi, lo} !== exp) $display("FAIL start_beats_mthi got %h_%h want %h", hi, lo, exp); else passed++;
    endtask

    task automatic test_divzero_mtlo;
        issue(2'd3, 32'd1234, 32'd0);
        wait_busy(1, 2, cyc);
        total++; if (cyc !== DIV_N) $display("FAIL divzero_busy_len got %0d want %0d", cyc, DIV_N); else passed++;
        exp = exp_q.pop_front();
        total++; if ({hi, lo} !== exp) $display("FAIL divzero_mtlo_busy got %h_%h want %h", hi, lo, exp); else passed++;
    endtask

    task automatic test_start_ignored;
        issue(2'd2, 32'd100, 32'd7);
        wait_busy(2, 3, cyc);
        total++; if (cyc !== DIV_N) $display("FAIL ignored_busy_len got %0d want %0d", cyc, DIV_N); else passed++;
        exp = exp_q.pop_front();
        total++; if ({hi, lo} !== exp) $display("FAIL ignored_result got %h_%h want %h", hi, lo, exp); else passed++;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL ignored_no_queue got %b want 0", busy); else passed++;
    endtask

    task automatic test_back_to_back;
        issue(2'd0, 32'h00012345, 32'hFFFF0000);
        wait_busy(0, 0, cyc);
        exp = exp_q.pop_front();
        total++; if ({hi, lo} !== exp) $display("FAIL b2b_mult got %h_%h want %h", hi, lo, exp); else passed++;
        issue(2'd3, 32'hF0000000, 32'd3);
        wait_busy(0, 0, cyc);
        total++; if (cyc !== DIV_N) $display("FAIL b2b_divu_len got %0d want %0d", cyc, DIV_N); else passed++;
        exp = exp_q.pop_front();
        total++; if ({hi, lo} !== exp) $display("FAIL b2b_divu got %h_%h want %h", hi, lo, exp); else passed++;
    endtask

    task automatic test_reset_mid;
        issue(2'd2, 32'd1000, 32'd3);
        wait_busy(3, 4, cyc);
        void'(exp_q.pop_back());
        model_hilo = 64'd0;
        total++; if (cyc !== 4) $display("FAIL rstmid_busy_drop got %0d want 4", cyc); else passed++;
        total++; if ({hi, lo} !== model_hilo) $display("FAIL rstmid_cleared got %h_%h want %h", hi, lo, model_hilo); else passed++;
        repeat (12) @(negedge clk);
        total++; if ({busy, hi, lo} !== {1'b0, model_hilo})
            $display("FAIL rstmid_no_late_write got %b %h_%h want 0 %h", busy, hi, lo, model_hilo); else passed++;
    endtask

    initial begin
        test_reset;
        test_mult;
        test_multu;
        test_div;
        test_moves;
        test_divzero_mtlo;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
